mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
Memory-side responder for the CPU's shared memory bus. It answers the read strobe (OE_M) and write strobe (WE_M) issued by the CPU or by bench bus tasks. It holds the RAM array and decodes the address against the valid memory map. It inserts a programmable number of wait states and signals completion with a one-cycle ready pulse and, where applicable, an error pulse. It replaces the zero-latency RAM so the control unit and bench can be exercised against a slow memory.

Parameters:
DATA_WIDTH, 8, data bus width (matches `DATA_WIDTH)
ADDR_WIDTH, 16, address bus width
MEM_DEPTH, 256, number of words implemented (matches `MEMORY_DEPTH); must be ≤ 2^(ADDR_WIDTH-1)
WAIT_STATES, 1, cycles between request capture and response (0..15)
CNT_WIDTH, 16, width of the transaction counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
address_bus  in  ADDR_WIDTH  transaction address
wdata  in  DATA_WIDTH  write data (data bus as driven by master)
OE_M  in  1  read strobe, held by master until ready/err
WE_M  in  1  write strobe, held by master until ready/err
rdata  out  DATA_WIDTH  read data
rdata_oe  out  1  responder drives data bus (tri-state enable at top level)
ready  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse, replaces ready
busy  out  1  transaction in progress
rd_count  out  CNT_WIDTH  completed good reads, saturating
wr_count  out  CNT_WIDTH  completed good writes, saturating
err_count  out  CNT_WIDTH  error responses, saturating

Behaviour:
- Reset (async, active-high): state=IDLE, rdata=0, rdata_oe=0, ready=0, err=0, busy=0, all counters=0. RAM contents are not cleared. A $readmemh preload survives reset.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE: on a rising edge with OE_M|WE_M=1, capture address, wdata and op. Set busy=1.
  - WAIT_STATES=0 -> go to RESP.
  - Otherwise load the wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the wait counter each cycle. At 0, go to RESP. Strobes are not re-sampled during WAIT.
- RESP (exactly one cycle):
  - Good write: mem[addr] <= captured wdata, ready=1, wr_count+1.
  - Good read: rdata=mem[addr], rdata_oe=1, ready=1, rd_count+1.
  - Error: err=1, ready=0, err_count+1, no RAM access, rdata=0, rdata_oe=0.
  - Next state is HOLD.
- Error conditions, decided at capture:
  - address_bus[ADDR_WIDTH-1]=1 (outside memory map);
  - address ≥ MEM_DEPTH;
  - OE_M and WE_M both asserted.
- HOLD: busy=1, rdata holds its value, rdata_oe=0. Return to IDLE once OE_M=0 and WE_M=0, with busy falling that cycle.
  - A strobe held indefinitely never causes a second transaction.
  - The next request needs strobes low for at least one cycle.
- Latency: request-capture edge to ready/err high = WAIT_STATES+1 rising edges.
- Strobe dropped during WAIT: the transaction still completes (write is committed, counters increment), then the FSM returns to IDLE from HOLD.
- Counters saturate at all-ones and do not wrap.
- Reset mid-transaction aborts it: no RAM write, no ready, counters cleared.
- rdata_oe is never high in the same cycle as err or when WE_M was the captured op.

Decomposition:
- Shared package/header (includes.vh): state encoding localparams (IDLE/WAIT/RESP/HOLD), op encoding (OP_RD, OP_WR), DATA_WIDTH/MEMORY_DEPTH defaults.
- One sub-module: sat_counter (parameterised width, inc, sync clear, async reset), instantiated three times.
- RAM array stays inline so bench hierarchical access (.mem) works.

Test Plan:
- Preload mem[0x02]=0x5A, WAIT_STATES=1; assert OE_M at addr 0x0002 -> ready and rdata_oe high 2 edges after capture, rdata=0x5A, rd_count=1.
- Write 0x25 to 0x0002, drop strobe, then read 0x0002 -> ready on each, rdata=0x25, wr_count=1, rd_count=1.
- Read 0x8000 and write 0x8002 -> err pulse each, ready=0, mem unchanged, err_count=2.
- OE_M and WE_M high together at 0x0010 -> err pulse, mem[0x10] unchanged. Strobe held 10 cycles -> exactly one err, busy until strobes drop.
- Sweep: write 255-i to addrs 0..255, then read all back -> all match, wr_count=rd_count=256; read of addr 0x0100 -> err.
- Assert reset during WAIT of a write 0x77 to 0x0003 -> no ready, mem[0x03] unchanged, counters=0, next read returns the old value.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared types and defaults for the memory bus responder.
// Contents: FSM state encoding, captured-operation encoding, default widths,
// and the wait-state counter width (supports 0..15 wait states).
package mem_bus_responder_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 8;
    localparam int unsigned ADDR_WIDTH_DEF  = 16;
    localparam int unsigned MEM_DEPTH_DEF   = 256;
    localparam int unsigned WAIT_STATES_DEF = 1;
    localparam int unsigned CNT_WIDTH_DEF   = 16;
    localparam int unsigned WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Shared memory bus between a master (CPU / bench tasks) and the responder.
// Master drives: address_bus, wdata, OE_M (read strobe), WE_M (write strobe).
// Responder drives: rdata, rdata_oe, ready, err, busy and the three
// transaction counters rd_count, wr_count, err_count.
interface mem_bus_responder_if
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) ();

    logic [ADDR_WIDTH-1:0] address_bus;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  OE_M;
    logic                  WE_M;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_oe;
    logic                  ready;
    logic                  err;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  rd_count;
    logic [CNT_WIDTH-1:0]  wr_count;
    logic [CNT_WIDTH-1:0]  err_count;

    modport master (
        output address_bus, wdata, OE_M, WE_M,
        input  rdata, rdata_oe, ready, err, busy, rd_count, wr_count, err_count
    );

    modport slave (
        input  address_bus, wdata, OE_M, WE_M,
        output rdata, rdata_oe, ready, err, busy, rd_count, wr_count, err_count
    );

endinterface

// File: rtl/mem_bus_responder_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Ports: clk, reset (async, active-high), i_inc (count enable),
//        i_clr (synchronous clear, wins over i_inc), o_count (registered value).
module mem_bus_responder_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_bus_responder.sv
// Slow-memory responder for the shared CPU memory bus.
// Captures a read/write strobe, waits WAIT_STATES cycles, then answers with a
// one-cycle ready (or err) pulse and holds until the master drops its strobes.
// Ports: clk, reset (async, active-high), bus (slave side of the memory bus:
//        address/wdata/strobes in; rdata, rdata_oe, ready, err, busy and
//        saturating rd/wr/err counters out).
// The RAM array 'mem' is inline and never reset so preloads survive reset.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_responder_if.slave bus
);

    localparam int unsigned MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned WS_LOAD = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [MEM_AW-1:0]     r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    op_t                   r_op;
    logic                  r_bad;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdata_oe;
    logic                  r_ready;
    logic                  r_err;
    logic                  r_busy;

    logic w_req;
    logic w_addr_bad;
    logic w_rd_inc;
    logic w_wr_inc;
    logic w_err_inc;

    assign w_req = bus.OE_M | bus.WE_M;

    // Outside the map (top bit set), past the implemented depth, or both strobes at once.
    assign w_addr_bad = bus.address_bus[ADDR_WIDTH-1]
                      | (bus.address_bus >= ADDR_WIDTH'(MEM_DEPTH))
                      | (bus.OE_M & bus.WE_M);

    // Counter bumps coincide with the edge that launches ready/err.
    assign w_rd_inc  = (r_state == ST_RESP) && !r_bad && (r_op == OP_RD);
    assign w_wr_inc  = (r_state == ST_RESP) && !r_bad && (r_op == OP_WR);
    assign w_err_inc = (r_state == ST_RESP) &&  r_bad;

    // Transaction FSM with registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_op       <= OP_RD;
            r_bad      <= 1'b0;
            r_rdata    <= '0;
            r_rdata_oe <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata_oe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_idx   <= bus.address_bus[MEM_AW-1:0];
                        r_wdata <= bus.wdata;
                        r_op    <= bus.WE_M ? OP_WR : OP_RD;
                        r_bad   <= w_addr_bad;
                        r_busy  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_wait_cnt <= WAIT_CNT_W'(WS_LOAD);
                            r_state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (r_bad) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else if (r_op == OP_RD) begin
                        r_rdata    <= mem[r_idx];
                        r_rdata_oe <= 1'b1;
                        r_ready    <= 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                    end
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Strobes must fall before IDLE can accept another request.
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port: commits only on a good write leaving RESP.
    always_ff @(posedge clk) begin
        if (w_wr_inc) begin
            mem[r_idx] <= r_wdata;
        end
    end

    mem_bus_responder_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_rd_inc),
        .i_clr   (1'b0),
        .o_count (bus.rd_count)
    );

    mem_bus_responder_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_wr_inc),
        .i_clr   (1'b0),
        .o_count (bus.wr_count)
    );

    mem_bus_responder_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_err_inc),
        .i_clr   (1'b0),
        .o_count (bus.err_count)
    );

    assign bus.rdata    = r_rdata;
    assign bus.rdata_oe = r_rdata_oe;
    assign bus.ready    = r_ready;
    assign bus.err      = r_err;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed scenarios plus random transactions,
// checked against an array/counter reference model of the memory bus rules.
module tb_mem_bus_responder;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned WS    = 1;
    localparam int unsigned CW    = 8;
    localparam int          CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;

    mem_bus_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus_if ();

    mem_bus_responder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (WS),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_mem [DEPTH];
    bit            model_vld [DEPTH];
    int            n_rd = 0;
    int            n_wr = 0;
    int            n_er = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_rd_count"},  32'(bus_if.rd_count),  32'(sat(n_rd)));
        chk({tag, "_wr_count"},  32'(bus_if.wr_count),  32'(sat(n_wr)));
        chk({tag, "_err_count"}, 32'(bus_if.err_count), 32'(sat(n_er)));
    endtask

    // One full bus transaction: request, response, optional strobe hold, release.
    task automatic txn(input logic oe, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input int hold, input bit drop);
        bit is_bad;
        bit seen;
        bit in_range;
        int k;
        int idx;
        is_bad   = (oe && we) || addr[AW-1] || (32'(addr) >= DEPTH);
        in_range = (32'(addr) < DEPTH);
        idx      = int'(addr[7:0]);
        @(negedge clk);
        bus_if.address_bus = addr;
        bus_if.wdata       = data;
        bus_if.OE_M        = oe;
        bus_if.WE_M        = we;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("busy_capture", 32'(bus_if.busy), 32'(1));
                if (drop) begin
                    bus_if.OE_M = 1'b0;
                    bus_if.WE_M = 1'b0;
                end
            end
            if (bus_if.ready || bus_if.err) seen = 1'b1;
        end
        if (!seen) begin
            chk("timeout", 32'(k), 32'(WS + 2));
            bus_if.OE_M = 1'b0;
            bus_if.WE_M = 1'b0;
            return;
        end
        chk("latency",  32'(k),               32'(WS + 2));
        chk("ready",    32'(bus_if.ready),    32'(!is_bad));
        chk("err",      32'(bus_if.err),      32'(is_bad));
        chk("rdata_oe", 32'(bus_if.rdata_oe), 32'(!is_bad && !we));
        if (is_bad) begin
            n_er++;
            chk("rdata_err", 32'(bus_if.rdata), 32'(0));
        end else if (we) begin
            n_wr++;
            model_mem[idx] = data;
            model_vld[idx] = 1'b1;
        end else begin
            n_rd++;
            if (model_vld[idx]) chk("rdata", 32'(bus_if.rdata), 32'(model_mem[idx]));
        end
        chk_counts("resp");
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("no_repeat", 32'({bus_if.ready, bus_if.err}), 32'(0));
            chk("busy_hold", 32'(bus_if.busy), 32'(1));
            chk("oe_hold",   32'(bus_if.rdata_oe), 32'(0));
            if (!is_bad && !we && model_vld[idx])
                chk("rdata_hold", 32'(bus_if.rdata), 32'(model_mem[idx]));
        end
        bus_if.OE_M = 1'b0;
        bus_if.WE_M = 1'b0;
        @(negedge clk);
        chk("busy_drop", 32'(bus_if.busy), 32'(0));
        chk("pulse_end", 32'({bus_if.ready, bus_if.err, bus_if.rdata_oe}), 32'(0));
        if (in_range && model_vld[idx])
            chk("mem", 32'(dut.mem[idx]), 32'(model_mem[idx]));
    endtask

    initial begin
        logic [AW-1:0] a;
        logic          o;
        logic          w;
        int            r;

        for (int i = 0; i < int'(DEPTH); i++) model_vld[i] = 1'b0;
        reset              = 1'b1;
        bus_if.address_bus = '0;
        bus_if.wdata       = '0;
        bus_if.OE_M        = 1'b0;
        bus_if.WE_M        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus_if.ready),    32'(0));
        chk("rst_err",   32'(bus_if.err),      32'(0));
        chk("rst_busy",  32'(bus_if.busy),     32'(0));
        chk("rst_oe",    32'(bus_if.rdata_oe), 32'(0));
        chk("rst_rdata", 32'(bus_if.rdata),    32'(0));
        chk_counts("rst");
        reset = 1'b0;
        @(negedge clk);

        // Preload then read back.
        txn(1'b0, 1'b1, 16'h0002, 8'h5A, 0, 1'b0);
        txn(1'b1, 1'b0, 16'h0002, 8'h00, 2, 1'b0);
        // Write with strobe dropped during WAIT, then read.
        txn(1'b0, 1'b1, 16'h0002, 8'h25, 0, 1'b1);
        txn(1'b1, 1'b0, 16'h0002, 8'h00, 0, 1'b0);
        // Out-of-map accesses.
        txn(1'b1, 1'b0, 16'h8000, 8'h00, 0, 1'b0);
        txn(1'b0, 1'b1, 16'h8002, 8'hAA, 0, 1'b0);
        chk("mem02_keep", 32'(dut.mem[2]), 32'(model_mem[2]));
        // Both strobes, held 10 cycles.
        txn(1'b0, 1'b1, 16'h0010, 8'h3C, 0, 1'b0);
        txn(1'b1, 1'b1, 16'h0010, 8'hFF, 10, 1'b0);

        // Full sweep (counters saturate at 8 bits here).
        for (int i = 0; i < int'(DEPTH); i++) txn(1'b0, 1'b1, AW'(i), DW'(255 - i), 0, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) txn(1'b1, 1'b0, AW'(i), 8'h00, 0, 1'b0);
        txn(1'b1, 1'b0, 16'h0100, 8'h00, 0, 1'b0);

        // Reset during WAIT of a write aborts it.
        @(negedge clk);
        bus_if.address_bus = 16'h0003;
        bus_if.wdata       = 8'h77;
        bus_if.WE_M        = 1'b1;
        @(negedge clk);
        chk("abort_busy_pre", 32'(bus_if.busy), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'({bus_if.ready, bus_if.err}), 32'(0));
        chk("abort_busy",  32'(bus_if.busy), 32'(0));
        bus_if.WE_M = 1'b0;
        reset       = 1'b0;
        n_rd = 0;
        n_wr = 0;
        n_er = 0;
        chk_counts("abort");
        repeat (3) @(negedge clk);
        chk("abort_ready_late", 32'({bus_if.ready, bus_if.err}), 32'(0));
        chk("abort_mem", 32'(dut.mem[3]), 32'(model_mem[3]));
        txn(1'b1, 1'b0, 16'h0003, 8'h00, 0, 1'b0);

        // Random traffic.
        for (int t = 0; t < 200; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 16'h8000 | AW'($urandom_range(0, 255));
            else if (r == 1) a = 16'h0100 + AW'($urandom_range(0, 16'h7EFF));
            else             a = AW'($urandom_range(0, DEPTH - 1));
            r = int'($urandom_range(0, 9));
            o = (r < 5) || (r == 9);
            w = (r >= 5);
            if ($urandom_range(0, 3) == 0)
                txn(o, w, a, DW'($urandom), 0, 1'b1);
            else
                txn(o, w, a, DW'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
